// File: rtl/gt_compare_arbiter_pkg.sv
// Shared FSM state encoding for gt_compare_arbiter and its comparator.
package gt_compare_arbiter_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gt_compare_arbiter_cmp.sv
// gt_cmp_nb: combinational unsigned comparator shared by all requesters.
// Optional equality output is present when GT_ARB_EQ_EN is defined.
module gt_cmp_nb #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_gt
`ifdef GT_ARB_EQ_EN
    ,
    output logic         o_eq
`endif
);

    // Unsigned magnitude (and optional equality) compare of the two operands.
    always_comb begin
        o_gt = (i_a > i_b);
`ifdef GT_ARB_EQ_EN
        o_eq = (i_a == i_b);
`endif
    end

endmodule

// File: rtl/gt_compare_arbiter.sv
// gt_compare_arbiter: round-robin arbiter in front of one shared unsigned
// greater-than comparator. One comparison in flight; result returned on a
// one-cycle rsp_valid strobe tagged with the requester index.
// Optional build macro GT_ARB_EQ_EN adds the rsp_eq output.
module gt_compare_arbiter
    import gt_compare_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 2,
    parameter int unsigned IDXW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_flat,
    input  logic [NREQ*W-1:0] b_flat,
    output logic [NREQ-1:0]   grant,
    output logic              rsp_valid,
    output logic [IDXW-1:0]   rsp_id,
    output logic              rsp_gt,
    output logic              busy
`ifdef GT_ARB_EQ_EN
    ,
    output logic              rsp_eq
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   r_rsp_id;
    logic [W-1:0]      r_opa;
    logic [W-1:0]      r_opb;
    logic              r_rsp_gt;
    logic [NREQ-1:0]   r_grant;
    logic              w_found;
    logic [IDXW-1:0]   w_pick;
    logic [W-1:0]      w_sel_a;
    logic [W-1:0]      w_sel_b;
    logic              w_gt;
`ifdef GT_ARB_EQ_EN
    logic              r_rsp_eq;
    logic              w_eq;
`endif

    gt_cmp_nb #(.W(W)) u_cmp (
        .i_a  (r_opa),
        .i_b  (r_opb),
        .o_gt (w_gt)
`ifdef GT_ARB_EQ_EN
        ,
        .o_eq (w_eq)
`endif
    );

    // Rotating-priority pick: first set request at or above rr_ptr, wrapping.
    // rr_ptr < NREQ always holds, so one conditional subtract implements the wrap.
    always_comb begin
        int unsigned j;
        w_found = 1'b0;
        w_pick  = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(r_rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_pick  = IDXW'(j);
                w_sel_a = a_flat[j*W +: W];
                w_sel_b = b_flat[j*W +: W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> CMP on any request, then RESP, then back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_found ? S_CMP : S_IDLE;
            S_CMP:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath registers. rsp_id gets its own register loaded with the result
    // so it holds its previous value while the next request is being compared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_rsp_id <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rsp_gt <= 1'b0;
            r_grant  <= '0;
`ifdef GT_ARB_EQ_EN
            r_rsp_eq <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_pick;
                        r_opa   <= w_sel_a;
                        r_opb   <= w_sel_b;
                        r_grant <= NREQ'(1) << w_pick;
                    end
                end
                S_CMP: begin
                    r_grant  <= '0;
                    r_rsp_gt <= w_gt;
                    r_rsp_id <= r_idx;
`ifdef GT_ARB_EQ_EN
                    r_rsp_eq <= w_eq;
`endif
                end
                S_RESP: begin
                    r_rr_ptr <= (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state and result registers.
    always_comb begin
        busy      = (r_state != S_IDLE);
        rsp_valid = (r_state == S_RESP);
        grant     = r_grant;
        rsp_id    = r_rsp_id;
        rsp_gt    = r_rsp_gt;
`ifdef GT_ARB_EQ_EN
        rsp_eq    = r_rsp_eq;
`endif
    end

endmodule
